esm_issue_window: RTL and testbench

Instruction window manager wrapped around the ESM dependency-analysis core. It accepts decoded instructions from fetch/decode and allocates them circularly into `bs` buffer slots. It drives each allocation into the dependency core (slot index, instruction word, `RegWrite`, `ALUSrc`) and publishes the `valid_entries` bitmap. It consumes the core's `independent_instr` vector and issues the oldest eligible entry downstream over a valid/ready port, then frees the slot on a completion report.

---
 rtl/esm_pkg.sv | 13 +
 rtl/esm_age_select.sv | 30 +++
 rtl/esm_issue_window.sv | 127 ++++++++++++
 tb/tb_esm_issue_window.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared ESM constants, slot-width helper and slot-index type.
package esm_pkg;

    localparam logic [31:0] ESM_NOP        = 32'h0000_0013;
    localparam int          ESM_BS_DEFAULT = 16;

    function automatic int bs_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [bs_bits(ESM_BS_DEFAULT)-1:0] slot_idx_t;

endpackage

// File: rtl/esm_age_select.sv
// Rotating priority encoder: first set request at or after start, wrapping.
module esm_age_select
    import esm_pkg::*;
#(
    parameter int N = 16,
    parameter int W = bs_bits(N)
) (
    input  logic [0:N-1] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] k;

    // N is a power of two, so the W-bit sum wraps naturally
    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = start + W'(i);
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/esm_issue_window.sv
// Circular instruction window: allocates at tail, feeds the dependency core,
// issues the oldest eligible entry and frees slots on completion.
module esm_issue_window
    import esm_pkg::*;
#(
    parameter int Instruction_word_size = 32,
    parameter int bs                    = 16,
    parameter int ELIG_DELAY            = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [Instruction_word_size-1:0] in_instr,
    input  logic                             in_regwrite,
    input  logic                             in_alusrc,
    output logic [$clog2(bs)-1:0]            ida_buffer_index,
    output logic [Instruction_word_size-1:0] ida_instr,
    output logic                             ida_regwrite,
    output logic                             ida_alusrc,
    output logic [0:bs-1]                    valid_entries,
    input  logic [0:bs-1]                    independent_instr,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [$clog2(bs)-1:0]            issue_index,
    output logic [Instruction_word_size-1:0] issue_instr,
    input  logic                             complete_valid,
    input  logic [$clog2(bs)-1:0]            complete_index
);

    localparam int W  = bs_bits(bs);
    localparam int SW = (ELIG_DELAY < 1) ? 1 : $clog2(ELIG_DELAY + 1);

    logic [0:bs-1]                    valid;
    logic [0:bs-1]                    issued;
    logic [SW-1:0]                    settle     [bs];
    logic [Instruction_word_size-1:0] slot_instr [bs];
    logic [W-1:0]                     tail;
    logic [0:bs-1]                    eligible;
    logic                             found;
    logic [W-1:0]                     pick;
    logic                             accept;
    logic                             complete_hit;
    logic                             issue_load;

    assign in_ready         = !rst && !valid[tail];
    assign accept           = in_valid && in_ready;
    assign complete_hit     = complete_valid && valid[complete_index] && issued[complete_index];
    assign issue_load       = !issue_valid || issue_ready;
    assign valid_entries    = valid;
    assign ida_buffer_index = tail;

    always_comb begin
        ida_instr    = Instruction_word_size'(ESM_NOP);
        ida_regwrite = 1'b0;
        ida_alusrc   = 1'b1;
        if (accept) begin
            ida_instr    = in_instr;
            ida_regwrite = in_regwrite;
            ida_alusrc   = in_alusrc;
        end
    end

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < bs; i++) begin
            eligible[i] = valid[i] & ~issued[i] & (settle[i] == SW'(ELIG_DELAY))
                        & independent_instr[i];
        end
    end

    // Scanning from tail visits entries oldest-first since allocation never skips a slot
    esm_age_select #(
        .N(bs),
        .W(W)
    ) u_age_select (
        .req  (eligible),
        .start(tail),
        .found(found),
        .idx  (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= '0;
            issued      <= '0;
            tail        <= '0;
            issue_valid <= 1'b0;
            issue_index <= '0;
            issue_instr <= '0;
            for (int unsigned i = 0; i < bs; i++) begin
                settle[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < bs; i++) begin
                if (settle[i] != SW'(ELIG_DELAY)) begin
                    settle[i] <= settle[i] + 1'b1;
                end
            end
            if (accept) begin
                valid[tail]  <= 1'b1;
                issued[tail] <= 1'b0;
                settle[tail] <= '0;
                tail         <= tail + 1'b1;
            end
            if (complete_hit) begin
                valid[complete_index]  <= 1'b0;
                issued[complete_index] <= 1'b0;
            end
            if (issue_load) begin
                issue_valid <= found;
                if (found) begin
                    issue_index  <= pick;
                    issue_instr  <= slot_instr[pick];
                    issued[pick] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            slot_instr[tail] <= in_instr;
        end
    end

endmodule

// File: tb/tb_esm_issue_window.sv
// Directed self-checking bench for esm_issue_window (bs=16, ELIG_DELAY=2).
module tb_esm_issue_window;
    import esm_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        in_regwrite;
    logic        in_alusrc;
    slot_idx_t   ida_buffer_index;
    logic [31:0] ida_instr;
    logic        ida_regwrite;
    logic        ida_alusrc;
    logic [0:15] valid_entries;
    logic [0:15] independent_instr;
    logic        issue_valid;
    logic        issue_ready;
    slot_idx_t   issue_index;
    logic [31:0] issue_instr;
    logic        complete_valid;
    slot_idx_t   complete_index;

    int checks = 0;
    int passed = 0;

    esm_issue_window #(
        .Instruction_word_size(32),
        .bs                   (16),
        .ELIG_DELAY           (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instr         (in_instr),
        .in_regwrite      (in_regwrite),
        .in_alusrc        (in_alusrc),
        .ida_buffer_index (ida_buffer_index),
        .ida_instr        (ida_instr),
        .ida_regwrite     (ida_regwrite),
        .ida_alusrc       (ida_alusrc),
        .valid_entries    (valid_entries),
        .independent_instr(independent_instr),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_index      (issue_index),
        .issue_instr      (issue_instr),
        .complete_valid   (complete_valid),
        .complete_index   (complete_index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        in_valid          = 1'b0;
        in_instr          = '0;
        in_regwrite       = 1'b0;
        in_alusrc         = 1'b0;
        independent_instr = '0;
        issue_ready       = 1'b0;
        complete_valid    = 1'b0;
        complete_index    = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during: got %b want 0", in_ready); else passed++;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after: got %b want 1", in_ready); else passed++;
        checks++; if (valid_entries !== 16'h0000) $display("FAIL reset_valid_entries: got %h want 0000", valid_entries); else passed++;
        checks++; if (ida_instr !== NOP) $display("FAIL reset_ida_instr: got %h want %h", ida_instr, NOP); else passed++;
        checks++; if (ida_regwrite !== 1'b0 || ida_alusrc !== 1'b1) $display("FAIL reset_ida_ctl: got rw=%b as=%b want rw=0 as=1", ida_regwrite, ida_alusrc); else passed++;
        checks++; if (ida_buffer_index !== 4'd0) $display("FAIL reset_ida_index: got %0d want 0", ida_buffer_index); else passed++;
        checks++; if (issue_valid !== 1'b0 || issue_index !== 4'd0 || issue_instr !== 32'h0) $display("FAIL reset_issue: got v=%b i=%0d w=%h want 0/0/0", issue_valid, issue_index, issue_instr); else passed++;
    endtask

    task automatic test_single_issue();
        do_reset();
        independent_instr = 16'hFFFF;
        issue_ready       = 1'b1;
        in_valid          = 1'b1;
        in_instr          = 32'hA000_0001;
        in_regwrite       = 1'b1;
        in_alusrc         = 1'b0;
        #1;
        checks++; if (ida_instr !== 32'hA000_0001) $display("FAIL single_ida_instr: got %h want a0000001", ida_instr); else passed++;
        checks++; if (ida_regwrite !== 1'b1 || ida_alusrc !== 1'b0) $display("FAIL single_ida_ctl: got rw=%b as=%b want rw=1 as=0", ida_regwrite, ida_alusrc); else passed++;
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (valid_entries !== 16'h8000) $display("FAIL single_valid_entries: got %h want 8000", valid_entries); else passed++;
        checks++; if (ida_buffer_index !== 4'd1) $display("FAIL single_tail: got %0d want 1", ida_buffer_index); else passed++;
        checks++; if (issue_valid !== 1'b0) $display("FAIL single_early1: got %b want 0", issue_valid); else passed++;
        tick();
        checks++; if (issue_valid !== 1'b0) $display("FAIL single_early2: got %b want 0", issue_valid); else passed++;
        tick();
        checks++; if (issue_valid !== 1'b0) $display("FAIL single_early3: got %b want 0", issue_valid); else passed++;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd0 || issue_instr !== 32'hA000_0001) $display("FAIL single_issue: got v=%b i=%0d w=%h want 1/0/a0000001", issue_valid, issue_index, issue_instr); else passed++;
        tick();
        checks++; if (issue_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", issue_valid); else passed++;
    endtask

    task automatic test_fill_wrap();
        do_reset();
        issue_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h100 + i;
            tick();
        end
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", in_ready); else passed++;
        checks++; if (valid_entries !== 16'hFFFF) $display("FAIL full_valid_entries: got %h want ffff", valid_entries); else passed++;
        checks++; if (ida_instr !== NOP) $display("FAIL full_ida_nop: got %h want %h", ida_instr, NOP); else passed++;
        independent_instr = 16'h8000;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd0 || issue_instr !== 32'h100) $display("FAIL full_issue0: got v=%b i=%0d w=%h want 1/0/00000100", issue_valid, issue_index, issue_instr); else passed++;
        complete_valid = 1'b1;
        complete_index = 4'd0;
        tick();
        complete_valid = 1'b0;
        in_instr       = 32'h0000_BEEF;
        #1;
        checks++; if (valid_entries !== 16'h7FFF) $display("FAIL free_valid_entries: got %h want 7fff", valid_entries); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL free_in_ready: got %b want 1", in_ready); else passed++;
        checks++; if (ida_instr !== 32'h0000_BEEF || ida_buffer_index !== 4'd0) $display("FAIL free_ida: got w=%h i=%0d want 0000beef/0", ida_instr, ida_buffer_index); else passed++;
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (valid_entries !== 16'hFFFF) $display("FAIL wrap_valid_entries: got %h want ffff", valid_entries); else passed++;
        checks++; if (ida_buffer_index !== 4'd1) $display("FAIL wrap_tail: got %0d want 1", ida_buffer_index); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL wrap_in_ready: got %b want 0", in_ready); else passed++;
    endtask

    task automatic test_back_to_back_order();
        do_reset();
        issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h200 + i;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        independent_instr = 16'h5000;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd1 || issue_instr !== 32'h201) $display("FAIL order_first: got v=%b i=%0d w=%h want 1/1/00000201", issue_valid, issue_index, issue_instr); else passed++;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd3 || issue_instr !== 32'h203) $display("FAIL order_second: got v=%b i=%0d w=%h want 1/3/00000203", issue_valid, issue_index, issue_instr); else passed++;
        independent_instr = 16'hD000;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd0 || issue_instr !== 32'h200) $display("FAIL order_third: got v=%b i=%0d w=%h want 1/0/00000200", issue_valid, issue_index, issue_instr); else passed++;
        tick();
        checks++; if (issue_valid !== 1'b0) $display("FAIL order_drain: got %b want 0", issue_valid); else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h300 + i;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        independent_instr = 16'hFFFF;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd0 || issue_instr !== 32'h300) $display("FAIL stall_load: got v=%b i=%0d w=%h want 1/0/00000300", issue_valid, issue_index, issue_instr); else passed++;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd0 || issue_instr !== 32'h300) $display("FAIL stall_hold%0d: got v=%b i=%0d w=%h want 1/0/00000300", c, issue_valid, issue_index, issue_instr); else passed++;
        end
        issue_ready = 1'b1;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd1 || issue_instr !== 32'h301) $display("FAIL stall_next1: got v=%b i=%0d w=%h want 1/1/00000301", issue_valid, issue_index, issue_instr); else passed++;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd2 || issue_instr !== 32'h302) $display("FAIL stall_next2: got v=%b i=%0d w=%h want 1/2/00000302", issue_valid, issue_index, issue_instr); else passed++;
        tick();
        checks++; if (issue_valid !== 1'b0) $display("FAIL stall_drain: got %b want 0", issue_valid); else passed++;
    endtask

    task automatic test_ignore_and_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h400 + i;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        independent_instr = 16'h8000;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd0) $display("FAIL ign_issue: got v=%b i=%0d want 1/0", issue_valid, issue_index); else passed++;
        complete_valid = 1'b1;
        complete_index = 4'd1;
        tick();
        complete_index = 4'd5;
        tick();
        complete_valid = 1'b0;
        #1;
        checks++; if (valid_entries !== 16'hC000) $display("FAIL ign_valid_entries: got %h want c000", valid_entries); else passed++;
        checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd0 || issue_instr !== 32'h400) $display("FAIL ign_issue_hold: got v=%b i=%0d w=%h want 1/0/00000400", issue_valid, issue_index, issue_instr); else passed++;
        checks++; if (in_ready !== 1'b1 || ida_buffer_index !== 4'd2) $display("FAIL ign_tail: got rdy=%b i=%0d want 1/2", in_ready, ida_buffer_index); else passed++;
        rst            = 1'b1;
        complete_valid = 1'b1;
        complete_index = 4'd0;
        in_valid       = 1'b1;
        in_instr       = 32'h0000_0555;
        #1;
        checks++; if (in_ready !== 1'b0 || ida_instr !== NOP) $display("FAIL midrst_comb: got rdy=%b w=%h want 0/%h", in_ready, ida_instr, NOP); else passed++;
        tick();
        checks++; if (issue_valid !== 1'b0 || issue_index !== 4'd0 || issue_instr !== 32'h0) $display("FAIL midrst_issue: got v=%b i=%0d w=%h want 0/0/0", issue_valid, issue_index, issue_instr); else passed++;
        checks++; if (valid_entries !== 16'h0000) $display("FAIL midrst_valid_entries: got %h want 0000", valid_entries); else passed++;
        rst            = 1'b0;
        complete_valid = 1'b0;
        in_valid       = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || ida_buffer_index !== 4'd0 || ida_alusrc !== 1'b1) $display("FAIL midrst_after: got rdy=%b i=%0d as=%b want 1/0/1", in_ready, ida_buffer_index, ida_alusrc); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_fill_wrap();
        test_back_to_back_order();
        test_stall();
        test_ignore_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
